// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver with a 2-flop input synchroniser, registered byte/strobe outputs and a PC-advance pulse.
// Optional even-parity (8E1) support is enabled by defining UART_RX_PARITY_EN.
//
// state   | meaning
// IDLE    | line idle, waiting for a low on rx_s
// START   | confirming the start bit at its mid-point
// DATA    | sampling DATA_W data bits, LSB first
// PARITY  | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling the stop bit; commit byte or flag an error
// CLEANUP | one cycle that produces rx_PC_E
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_W       = 8
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic              rx_reset,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_PC_E,
  output logic              rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q, done_d;
  logic               pce_q, pce_d;
  logic               ferr_q, ferr_d;
  logic               sync1_q, sync2_q;
  logic               rx_s;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               perr_q, perr_d;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    pce_d     = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (rx_reset) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          if (!rx_s) state_d = START;
        end
        START: begin
          if (clk_cnt_q == CNT_MID) begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d          = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = '0;
            par_d     = rx_s;
            state_d   = STOP;
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = '0;
            state_d   = IDLE;
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = CLEANUP;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        CLEANUP: begin
          pce_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      pce_q     <= 1'b0;
      ferr_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      pce_q     <= pce_d;
      ferr_q    <= ferr_d;
      sync1_q   <= rx_reset ? 1'b1 : rx_serial;
      sync2_q   <= rx_reset ? 1'b1 : sync1_q;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign rx_PC_E   = pce_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at CLKS_PER_BIT=8: scoreboard of expected bytes checked on rx_done.
module tb_uart_rx_frame;
  localparam int CPB = 8;

  logic       rx_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_reset = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_PC_E, rx_busy, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .rx_clk    (rx_clk),
    .rst_n     (rst_n),
    .rx_reset  (rx_reset),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_PC_E   (rx_PC_E),
    .rx_busy   (rx_busy),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  always #5 rx_clk = ~rx_clk;

  // Output monitor: pops the scoreboard on every rx_done and checks pulse relationships.
  always @(negedge rx_clk) begin : mon
    logic [7:0] e;
    int npulse;
    if (rst_n) begin
      if (rx_done) begin
        done_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: rx_data=%h with no byte expected", rx_data);
        end else begin
          e = exp_q.pop_front();
          last_good = e;
          if (rx_data !== e) begin
            bad++;
            $display("FAIL rx_data: got %h expected %h", rx_data, e);
          end
        end
      end
      if (prev_done || rx_PC_E) begin
        total++;
        if (rx_PC_E !== prev_done) begin
          bad++;
          $display("FAIL pc_e_follow: rx_PC_E=%b previous rx_done=%b", rx_PC_E, prev_done);
        end
      end
      npulse = int'(rx_done) + int'(rx_PC_E) + int'(frame_err);
`ifdef UART_RX_PARITY_EN
      npulse += int'(parity_err);
      if (parity_err) perr_cnt++;
`endif
      if (npulse > 1) begin
        total++;
        bad++;
        $display("FAIL pulse_overlap: done=%b pc_e=%b ferr=%b", rx_done, rx_PC_E, frame_err);
      end
      if (frame_err) begin
        ferr_cnt++;
        total++;
        if (prev_ferr) begin
          bad++;
          $display("FAIL ferr_width: frame_err high two cycles, expected 1");
        end
      end
      prev_done = rx_done;
      prev_ferr = frame_err;
    end
  end

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge rx_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
    rx_serial = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge rx_clk);
    total += 5;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", rx_done); end
    if (rx_PC_E !== 1'b0) begin bad++; $display("FAIL reset_pce: got %b expected 0", rx_PC_E); end
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * CPB);
    total += 4;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
    if (ferr_cnt !== f0) begin bad++; $display("FAIL single_ferr: got %0d errors expected 0", ferr_cnt - f0); end
    if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h expected a5", rx_data); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL single_pending: %0d bytes left expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    logic saw_busy = 1'b0;
    logic dropped = 1'b0;
    rx_serial = 1'b0;
    repeat (2) @(negedge rx_clk);
    rx_serial = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge rx_clk);
      if (rx_busy) saw_busy = 1'b1;
      else if (saw_busy) begin dropped = 1'b1; break; end
    end
    total += 3;
    if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise: busy seen=%b expected 1", saw_busy); end
    if (dropped !== 1'b1) begin bad++; $display("FAIL glitch_busy_drop: dropped=%b expected 1 within 6 cycles", dropped); end
    idle(2 * CPB);
    if (done_cnt !== d0) begin bad++; $display("FAIL glitch_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    logic [7:0] keep = last_good;
    send_frame(8'h55, 1'b0, 1'b0);
    idle(3 * CPB);
    total += 3;
    if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    if (done_cnt !== d0) begin bad++; $display("FAIL ferr_done: got %0d pulses expected 0", done_cnt - d0); end
    if (rx_data !== keep) begin bad++; $display("FAIL ferr_data: got %h expected %h", rx_data, keep); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(2 * CPB);
    total += 3;
    if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    if (rx_data !== 8'hC3) begin bad++; $display("FAIL b2b_data: got %h expected c3", rx_data); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_pending: %0d bytes left expected 0", exp_q.size()); end
  endtask

  task automatic test_rx_reset();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_serial = 1'b1;
    repeat (CPB / 2) @(negedge rx_clk);
    total += 2;
    if (rx_busy !== 1'b1) begin bad++; $display("FAIL rxreset_busy_before: got %b expected 1", rx_busy); end
    rx_reset = 1'b1;
    @(negedge rx_clk);
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL rxreset_idle: busy=%b expected 0", rx_busy); end
    rx_reset = 1'b0;
    idle(8 * CPB);
    total += 2;
    if (done_cnt !== d0) begin bad++; $display("FAIL rxreset_done: got %0d pulses expected 0", done_cnt - d0); end
    if (ferr_cnt !== f0) begin bad++; $display("FAIL rxreset_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2 * CPB);
    total += 2;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rxreset_next_count: got %0d expected 1", done_cnt - d0); end
    if (rx_data !== 8'h12) begin bad++; $display("FAIL rxreset_next_data: got %h expected 12", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int d0 = done_cnt;
    int p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    total += 2;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL parity_done: got %0d expected 1", done_cnt - d0); end
    if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_err: got %0d expected 1", perr_cnt - p0); end
  endtask
`endif

  initial begin
    @(negedge rx_clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_rx_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
